// File: rtl/slave_port.sv
// slave_port: slave-side responder of the 1-bit master/slave serial bus.
// It receives an address and, for writes, a data word, both serially and LSB
// first. It then performs one access on a local parallel memory interface.
// For reads it returns the memory word serially, LSB first.
// sready is high while the port is idle and can accept a new frame.
// Optional feature, enabled by defining SLAVE_PARITY_EN:
// - Write frames carry one extra even-parity beat over address and data.
//   A frame with a parity mismatch is dropped without a memory write.
// - Read responses carry one extra even-parity beat over the read data.

module slave_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int MAX_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW        = $clog2(MAX_WIDTH + 2);

`ifdef SLAVE_PARITY_EN
    localparam int SEND_BEATS = DATA_WIDTH + 1;
`else
    localparam int SEND_BEATS = DATA_WIDTH;
`endif

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] SEND_LAST = CW'(SEND_BEATS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        WRITE = 3'd3,
        RREQ  = 3'd4,
        RWAIT = 3'd5,
        RSEND = 3'd6
`ifdef SLAVE_PARITY_EN
        ,
        WPAR  = 3'd7
`endif
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    mode;
    logic [ADDR_WIDTH-1:0]   addr_sr;
    logic [DATA_WIDTH-1:0]   data_sr;
    logic [DATA_WIDTH-1:0]   rd_sr;
`ifdef SLAVE_PARITY_EN
    logic                    rd_par;
`endif

    // Bits arrive LSB first. Shifting each new bit in at the top therefore
    // leaves the first bit in bit 0 once the whole field has been received.
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] data_next;
    assign addr_next = {swdata, addr_sr[ADDR_WIDTH-1:1]};
    assign data_next = {swdata, data_sr[DATA_WIDTH-1:1]};

    // Frame sequencer: all bus and memory outputs are registered here.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values no matter how the branches are ordered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            mode      <= 1'b0;
            addr_sr   <= '0;
            data_sr   <= '0;
            rd_sr     <= '0;
`ifdef SLAVE_PARITY_EN
            rd_par    <= 1'b0;
`endif
            srdata    <= 1'b0;
            svalid    <= 1'b0;
            sready    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
        end else begin
            // Strobes default low, so each strobe pulses for a single cycle.
            mem_wen <= 1'b0;
            mem_ren <= 1'b0;

            case (state)
                IDLE: begin
                    if (mvalid) begin
                        mode    <= smode;
                        addr_sr <= addr_next;
                        cnt     <= CW'(1);
                        sready  <= 1'b0;
                        state   <= ADDR;
                    end
                end

                ADDR: begin
                    if (!mvalid) begin
                        cnt    <= '0;
                        sready <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        addr_sr <= addr_next;
                        if (cnt == ADDR_LAST) begin
                            cnt <= '0;
                            if (mode) begin
                                state <= WDATA;
                            end else begin
                                mem_addr <= addr_next;
                                mem_ren  <= 1'b1;
                                state    <= RREQ;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                WDATA: begin
                    if (!mvalid) begin
                        cnt    <= '0;
                        sready <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        data_sr <= data_next;
                        if (cnt == DATA_LAST) begin
                            cnt <= '0;
`ifdef SLAVE_PARITY_EN
                            state <= WPAR;
`else
                            mem_addr  <= addr_sr;
                            mem_wdata <= data_next;
                            mem_wen   <= 1'b1;
                            state     <= WRITE;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

`ifdef SLAVE_PARITY_EN
                WPAR: begin
                    if (mvalid && (swdata == ^{addr_sr, data_sr})) begin
                        mem_addr  <= addr_sr;
                        mem_wdata <= data_sr;
                        mem_wen   <= 1'b1;
                        state     <= WRITE;
                    end else begin
                        // A missing or wrong parity beat discards the frame.
                        sready <= 1'b1;
                        state  <= IDLE;
                    end
                end
`endif

                WRITE: begin
                    sready <= 1'b1;
                    state  <= IDLE;
                end

                RREQ: begin
                    state <= RWAIT;
                end

                RWAIT: begin
                    if (mem_rvalid) begin
                        rd_sr  <= mem_rdata >> 1;
`ifdef SLAVE_PARITY_EN
                        rd_par <= ^mem_rdata;
`endif
                        srdata <= mem_rdata[0];
                        svalid <= 1'b1;
                        cnt    <= CW'(1);
                        state  <= RSEND;
                    end
                end

                RSEND: begin
                    if (cnt == SEND_LAST) begin
                        srdata <= 1'b0;
                        svalid <= 1'b0;
                        sready <= 1'b1;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        rd_sr <= rd_sr >> 1;
`ifdef SLAVE_PARITY_EN
                        srdata <= (cnt == CW'(DATA_WIDTH)) ? rd_par : rd_sr[0];
`else
                        srdata <= rd_sr[0];
`endif
                    end
                end

                default: begin
                    sready <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_port.sv
// Testbench for slave_port. The bench plays two roles:
// - the bus master, which drives the serial frames;
// - the memory block, which records writes and answers reads after a chosen delay.
// A behavioural model holds the expected memory contents and the expected
// strobe counts, and checks the frame timing.
// SLAVE_PARITY_EN switches the bench between the plain and the parity frame formats.

module tb_slave_port;

    localparam int AW = 12;
    localparam int DW = 8;
`ifdef SLAVE_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic          clk;
    logic          rstn;
    logic          swdata;
    logic          smode;
    logic          mvalid;
    logic          srdata;
    logic          svalid;
    logic          sready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen;
    logic          mem_ren;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;

    slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .swdata     (swdata),
        .smode      (smode),
        .mvalid     (mvalid),
        .srdata     (srdata),
        .svalid     (svalid),
        .sready     (sready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Physical memory behind the port, and the model's view of what it should hold.
    logic [DW-1:0] phys_mem  [1 << AW];
    logic [DW-1:0] model_mem [1 << AW];
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;
    int            exp_wen = 0;
    int            exp_ren = 0;
    int            wen_seen = 0;
    int            ren_seen = 0;
    bit            mon_en = 1'b0;
    logic [AW-1:0] pool [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory side and the bus-wide rules that must hold on every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("strobe_excl", {31'd0, mem_wen & mem_ren}, 32'd0);
            if (!svalid) check("srdata_quiet", {31'd0, srdata}, 32'd0);
            if (mem_wen) begin
                wen_seen++;
                phys_mem[mem_addr] = mem_wdata;
            end
            if (mem_ren) ren_seen++;
        end
    end

    task automatic check_hold(input string tag);
        check({tag, "_addr_hold"}, {20'd0, mem_addr}, {20'd0, last_addr});
        check({tag, "_wdata_hold"}, {24'd0, mem_wdata}, {24'd0, last_wdata});
        check({tag, "_wen_count"}, wen_seen, exp_wen);
        check({tag, "_ren_count"}, ren_seen, exp_ren);
    endtask

    task automatic write_frame(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit bad_par);
        logic [AW+DW:0] frame;
        bit             ok;
        ok    = !(PAR == 1 && bad_par);
        frame = {(^{a, d}) ^ bad_par, d, a};
        check("w_ready_start", {31'd0, sready}, 32'd1);
        for (int i = 0; i < AW + DW + PAR; i++) begin
            mvalid = 1'b1;
            swdata = frame[i];
            smode  = (i == 0) ? 1'b1 : 1'($urandom);
            step();
            if (i == 0) check("w_busy", {31'd0, sready}, 32'd0);
        end
        if (ok) begin
            check("w_wen", {31'd0, mem_wen}, 32'd1);
            check("w_addr", {20'd0, mem_addr}, {20'd0, a});
            check("w_data", {24'd0, mem_wdata}, {24'd0, d});
            check("w_ready_n1", {31'd0, sready}, 32'd0);
            model_mem[a] = d;
            last_addr    = a;
            last_wdata   = d;
            exp_wen++;
            mvalid = 1'($urandom);
            swdata = 1'($urandom);
            step();
            mvalid = 1'b0;
            check("w_wen_drop", {31'd0, mem_wen}, 32'd0);
            check("w_ready_n2", {31'd0, sready}, 32'd1);
        end else begin
            mvalid = 1'b0;
            check("wp_no_wen", {31'd0, mem_wen}, 32'd0);
            check("wp_ready", {31'd0, sready}, 32'd1);
            step();
        end
        check_hold("w");
    endtask

    task automatic read_frame(input logic [AW-1:0] a, input int delay, input int rst_after);
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp;
        logic          exp_bit;
        check("r_ready_start", {31'd0, sready}, 32'd1);
        for (int i = 0; i < AW; i++) begin
            mvalid = 1'b1;
            swdata = a[i];
            smode  = (i == 0) ? 1'b0 : 1'($urandom);
            step();
        end
        check("r_ren", {31'd0, mem_ren}, 32'd1);
        check("r_addr", {20'd0, mem_addr}, {20'd0, a});
        raddr     = mem_addr;
        last_addr = a;
        exp_ren++;
        for (int i = 0; i < delay; i++) begin
            mvalid = 1'($urandom);
            swdata = 1'($urandom);
            step();
            check("r_wait_svalid", {31'd0, svalid}, 32'd0);
            check("r_wait_ren", {31'd0, mem_ren}, 32'd0);
            check("r_wait_busy", {31'd0, sready}, 32'd0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = phys_mem[raddr];
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = DW'($urandom);
        exp = model_mem[a];
        for (int i = 0; i < DW + PAR; i++) begin
            if (rst_after != 0 && i == rst_after) begin
                mvalid = 1'b0;
                rstn   = 1'b0;
                step();
                rstn = 1'b1;
                check("rst_svalid", {31'd0, svalid}, 32'd0);
                check("rst_srdata", {31'd0, srdata}, 32'd0);
                check("rst_ready", {31'd0, sready}, 32'd1);
                last_addr  = '0;
                last_wdata = '0;
                check_hold("rst");
                return;
            end
            exp_bit = (i < DW) ? exp[i] : ^exp;
            check("r_svalid", {31'd0, svalid}, 32'd1);
            check("r_bit", {31'd0, srdata}, {31'd0, exp_bit});
            check("r_busy", {31'd0, sready}, 32'd0);
            mvalid = 1'($urandom);
            swdata = 1'($urandom);
            step();
        end
        mvalid = 1'b0;
        check("r_end_svalid", {31'd0, svalid}, 32'd0);
        check("r_end_ready", {31'd0, sready}, 32'd1);
        check_hold("r");
    endtask

    task automatic abort_frame(input bit mode, input int nbeats);
        check("a_ready_start", {31'd0, sready}, 32'd1);
        for (int i = 0; i < nbeats; i++) begin
            mvalid = 1'b1;
            swdata = 1'($urandom);
            smode  = (i == 0) ? mode : 1'($urandom);
            step();
        end
        check("a_busy", {31'd0, sready}, 32'd0);
        mvalid = 1'b0;
        step();
        check("a_ready", {31'd0, sready}, 32'd1);
        check_hold("a");
    endtask

    initial begin
        int op;
        for (int i = 0; i < (1 << AW); i++) begin
            phys_mem[i]  = DW'($urandom);
            model_mem[i] = phys_mem[i];
        end
        for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
        rstn       = 1'b0;
        swdata     = 1'b0;
        smode      = 1'b0;
        mvalid     = 1'b0;
        mem_rdata  = '0;
        mem_rvalid = 1'b0;
        last_addr  = '0;
        last_wdata = '0;
        step();
        mon_en = 1'b1;
        step();
        check("rst_srdata0", {31'd0, srdata}, 32'd0);
        check("rst_svalid0", {31'd0, svalid}, 32'd0);
        check("rst_sready0", {31'd0, sready}, 32'd1);
        check("rst_addr0", {20'd0, mem_addr}, 32'd0);
        check("rst_wdata0", {24'd0, mem_wdata}, 32'd0);
        check("rst_wen0", {31'd0, mem_wen}, 32'd0);
        check("rst_ren0", {31'd0, mem_ren}, 32'd0);
        rstn = 1'b1;
        step();

        write_frame(12'h3A5, 8'hC6, 1'b0);
        read_frame(12'h3A5, 2, 0);

        abort_frame(1'b1, 5);
        write_frame(12'h001, 8'h5A, 1'b0);
        read_frame(12'h001, 1, 0);
        abort_frame(1'b0, AW - 1);
        abort_frame(1'b1, AW + 3);

        write_frame(12'hFFF, 8'hFF, 1'b0);
        write_frame(12'h000, 8'h00, 1'b0);
        read_frame(12'hFFF, 1, 0);
        read_frame(12'h000, 10, 0);

        read_frame(12'h3A5, 3, 3);
        write_frame(12'h123, 8'h45, 1'b0);
        read_frame(12'h123, 4, 0);

        // Reset in the middle of a write frame drops it without a memory access.
        for (int i = 0; i < AW + 3; i++) begin
            mvalid = 1'b1;
            swdata = 1'($urandom);
            smode  = (i == 0) ? 1'b1 : 1'b0;
            step();
        end
        mvalid = 1'b0;
        rstn   = 1'b0;
        step();
        rstn       = 1'b1;
        last_addr  = '0;
        last_wdata = '0;
        check("rstw_ready", {31'd0, sready}, 32'd1);
        check_hold("rstw");
        step();

        if (PAR == 1) begin
            write_frame(12'h010, 8'h03, 1'b1);
            write_frame(12'h010, 8'h03, 1'b0);
            read_frame(12'h010, 2, 0);
        end

        for (int k = 0; k < 60; k++) begin
            logic [AW-1:0] a;
            bit            md;
            a  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : AW'($urandom);
            op = $urandom_range(0, 9);
            if (op < 4) begin
                write_frame(a, DW'($urandom), (PAR == 1) && ($urandom_range(0, 3) == 0));
            end else if (op < 8) begin
                read_frame(a, $urandom_range(1, 6), 0);
            end else begin
                md = 1'($urandom);
                abort_frame(md, md ? $urandom_range(1, AW + DW + PAR - 1) : $urandom_range(1, AW - 1));
            end
            if ($urandom_range(0, 2) == 0) step();
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/slave_port.md
Name: slave_port

Overview:
- Serial-bus responder: the slave-side end of the 1-bit master/slave bus driven by the master port.
- Deserialises the address and write data sent by the master.
- Performs one access on a local parallel memory interface.
- For reads, serialises the memory data back to the master.
- Sits between the bus fabric (arbiter/mux) and the slave's memory block. Drives sready, which the arbiter uses for transaction completion.

Parameters:
- ADDR_WIDTH, 12, slave-local address bits received serially.
- DATA_WIDTH, 8, data bits per transfer.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- swdata  in  1  serial address/write data from master, LSB first
- smode  in  1  transfer mode from master, 0 read / 1 write; sampled only on the first beat
- mvalid  in  1  master beat valid
- srdata  out  1  serial read data to master, LSB first
- svalid  out  1  read data beat valid
- sready  out  1  1 = idle and able to accept a new frame
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_wen  out  1  one-cycle write strobe
- mem_ren  out  1  one-cycle read strobe
- mem_rdata  in  DATA_WIDTH  memory read data
- mem_rvalid  in  1  mem_rdata valid; arrives at least 1 cycle after mem_ren

Behaviour:
- Reset (rstn=0 at posedge):
  - state=IDLE, counters 0.
  - srdata=0, svalid=0, sready=1.
  - mem_addr=0, mem_wdata=0, mem_wen=0, mem_ren=0.
  - Reset mid-frame aborts with no memory access.
- States: IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RSEND.
- IDLE:
  - sready=1.
  - On mvalid=1: latch smode, shift swdata into addr bit 0, set bit counter=1, go to ADDR.
  - sready goes 0 the following cycle.
- ADDR: each cycle with mvalid=1 shifts the next address bit in.
  - After ADDR_WIDTH bits: mode=1 goes to WDATA; mode=0 goes to RREQ.
  - No idle beat between address and data.
- WDATA: DATA_WIDTH beats of swdata with mvalid=1, then WRITE.
- WRITE: one cycle, mem_wen=1 with mem_addr/mem_wdata valid; next state IDLE.
  - sready=1 on the cycle after the mem_wen cycle.
  - Write latency: last data beat sampled at edge N; mem_wen high in cycle N+1; sready=1 in cycle N+2.
- RREQ: one cycle, mem_ren=1 with mem_addr valid; then RWAIT.
- RWAIT: hold until mem_rvalid=1; latch mem_rdata; go to RSEND.
  - mvalid is ignored in RWAIT.
- RSEND:
  - svalid=1 for exactly DATA_WIDTH consecutive cycles.
  - srdata carries bit 0..DATA_WIDTH-1 in order.
  - Then IDLE, with svalid=0 and sready=1 on the same cycle.
- Abort: mvalid=0 in ADDR or WDATA before the frame is complete returns to IDLE next cycle. No mem strobe; partial address/data discarded.
- mvalid=1 outside IDLE/ADDR/WDATA is ignored; no back-to-back frame is accepted until sready=1.
- mem_wen and mem_ren are never high together; each is high at most one cycle per frame.
- srdata=0 whenever svalid=0.
- mem_addr/mem_wdata hold their last values between frames.

Optional Feature:
- Macro: SLAVE_PARITY_EN.
- Defined, write frames: one extra beat follows the last data bit, carrying even parity over address+data.
  - Mismatch: skip WRITE and return to IDLE (no mem_wen).
  - Match: normal write, latency measured from the parity beat.
- Defined, read frames: RSEND is extended by one beat (svalid held) carrying even parity of the read data.
- Undefined: no parity beats; frame lengths exactly as above.

Test Plan:
- Write: after reset, send addr 0x3A5, mode 1, data 0xC6 (20 beats) -> mem_wen pulses once with mem_addr=0x3A5, mem_wdata=0xC6; sready=1 two cycles after the last beat.
- Read: addr 0x3A5, mode 0 (12 beats), memory returns 0xC6 with rvalid 2 cycles after mem_ren -> svalid high 8 cycles, srdata 0,1,1,0,0,0,1,1; sready=1 after.
- Abort: mvalid dropped after 5 address beats -> no mem_wen/mem_ren; sready=1 next cycle; a following write to 0x001/0x5A completes correctly.
- Boundary: write 0xFFF/0xFF and 0x000/0x00, then read both back -> mem_addr and serial data exact; read with mem_rvalid delayed 10 cycles -> svalid stays 0 until rvalid.
- Reset mid-RSEND after 3 bits -> next cycle svalid=0, srdata=0, sready=1; a new frame is then accepted.
- SLAVE_PARITY_EN: write 0x010/0x03 with wrong parity -> no mem_wen; correct parity -> write; read of 0x03 -> 9 svalid beats, last beat 0.
